// File: rtl/kpn_pkg.sv
// Shared constants and BCD helper for the KPN operand channel.
package kpn_pkg;

  localparam int BCD_DIGITS    = 4;
  localparam int OPERAND_W     = 4 * BCD_DIGITS;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    QSEL_A = 2'd0,
    QSEL_B = 2'd1
  } queue_sel_e;

  // True when every nibble holds a decimal digit (0..9).
  function automatic logic is_bcd(input logic [OPERAND_W-1:0] data);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (data[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/kpn_operand_channel_if.sv
// Operand channel bus: producer writes on A/B, consumer pops joined pairs.
interface kpn_operand_channel_if
  import kpn_pkg::*;
#(
  parameter int DATA_W = OPERAND_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wr_a;
  logic [DATA_W-1:0] data_a;
  logic              full_a;
  logic              wr_b;
  logic [DATA_W-1:0] data_b;
  logic              full_b;
  logic              rd;
  logic              valid;
  logic [DATA_W-1:0] entry_1;
  logic [DATA_W-1:0] entry_2;
  logic [CNT_W-1:0]  count_a;
  logic [CNT_W-1:0]  count_b;
  logic              err_clr;
  logic              bcd_err;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_a, data_a, wr_b, data_b, rd, err_clr,
    input  full_a, full_b, valid, entry_1, entry_2, count_a, count_b,
           bcd_err, overflow, underflow
  );

  modport slave (
    input  wr_a, data_a, wr_b, data_b, rd, err_clr,
    output full_a, full_b, valid, entry_1, entry_2, count_a, count_b,
           bcd_err, overflow, underflow
  );

endinterface

// File: rtl/kpn_fifo_queue.sv
// Single-clock FIFO with show-ahead head; caller guarantees push only when
// not full and pop only when not empty.
module kpn_fifo_queue
  import kpn_pkg::*;
#(
  parameter int DATA_W = OPERAND_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wptr_r;
  logic [PTR_W-1:0]  rptr_r;
  logic [CNT_W-1:0]  count_r;

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push) wptr_r <= wptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      if (pop)  rptr_r <= rptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      case ({push, pop})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/kpn_operand_channel.sv
// Joins two BCD operand FIFOs into a pair stream with blocking-read
// semantics; malformed BCD and protocol misuse raise sticky flags.
module kpn_operand_channel
  import kpn_pkg::*;
#(
  parameter int DATA_W    = OPERAND_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int CHECK_BCD = 1
) (
  input logic                   clk,
  input logic                   reset_n,
  kpn_operand_channel_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              bcd_ok_a_s, bcd_ok_b_s;
  logic              push_a_s, push_b_s, pop_s, valid_s;
  logic              full_a_s, full_b_s;
  logic [DATA_W-1:0] head_a_s, head_b_s;
  logic [CNT_W-1:0]  count_a_s, count_b_s;
  logic              bcd_set_s, ovf_set_s, unf_set_s;
  logic              bcd_err_r, overflow_r, underflow_r;

  assign bcd_ok_a_s = (CHECK_BCD == 0) ? 1'b1 : is_bcd(bus.data_a);
  assign bcd_ok_b_s = (CHECK_BCD == 0) ? 1'b1 : is_bcd(bus.data_b);

  // Fullness is the registered value: a same-cycle pop never frees a slot.
  assign push_a_s = bus.wr_a & ~full_a_s & bcd_ok_a_s;
  assign push_b_s = bus.wr_b & ~full_b_s & bcd_ok_b_s;
  assign valid_s  = (count_a_s != {CNT_W{1'b0}}) & (count_b_s != {CNT_W{1'b0}});
  assign pop_s    = bus.rd & valid_s;

  assign bcd_set_s = (bus.wr_a & ~bcd_ok_a_s) | (bus.wr_b & ~bcd_ok_b_s);
  assign ovf_set_s = (bus.wr_a & full_a_s) | (bus.wr_b & full_b_s);
  assign unf_set_s = bus.rd & ~valid_s;

  kpn_fifo_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_queue_a (
    .clk(clk), .reset_n(reset_n), .push(push_a_s), .pop(pop_s),
    .wdata(bus.data_a), .rdata(head_a_s), .count(count_a_s), .full(full_a_s)
  );

  kpn_fifo_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_queue_b (
    .clk(clk), .reset_n(reset_n), .push(push_b_s), .pop(pop_s),
    .wdata(bus.data_b), .rdata(head_b_s), .count(count_b_s), .full(full_b_s)
  );

  // Sticky error flags; a new event outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_err_r   <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bcd_set_s)        bcd_err_r   <= 1'b1;
      else if (bus.err_clr) bcd_err_r   <= 1'b0;
      if (ovf_set_s)        overflow_r  <= 1'b1;
      else if (bus.err_clr) overflow_r  <= 1'b0;
      if (unf_set_s)        underflow_r <= 1'b1;
      else if (bus.err_clr) underflow_r <= 1'b0;
    end
  end

  // Present the joined pair only when both heads exist.
  always_comb begin
    bus.entry_1 = {DATA_W{1'b0}};
    bus.entry_2 = {DATA_W{1'b0}};
    if (valid_s) begin
      bus.entry_1 = head_a_s;
      bus.entry_2 = head_b_s;
    end else begin
      bus.entry_1 = {DATA_W{1'b0}};
      bus.entry_2 = {DATA_W{1'b0}};
    end
  end

  assign bus.valid     = valid_s;
  assign bus.full_a    = full_a_s;
  assign bus.full_b    = full_b_s;
  assign bus.count_a   = count_a_s;
  assign bus.count_b   = count_b_s;
  assign bus.bcd_err   = bcd_err_r;
  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;

endmodule

// File: tb/tb_kpn_operand_channel.sv
// Directed bench for kpn_operand_channel with a queue-based pair scoreboard.
module tb_kpn_operand_channel;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   cnt_a, cnt_b;
  logic exp_bcd, exp_ovf, exp_unf;
  logic mon_en;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  kpn_operand_channel_if #(.DATA_W(16), .DEPTH(8)) bus ();

  kpn_operand_channel #(.DATA_W(16), .DEPTH(8), .CHECK_BCD(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_bcd(input logic [15:0] d);
    return (d[3:0] < 4'd10) && (d[7:4] < 4'd10) && (d[11:8] < 4'd10) && (d[15:12] < 4'd10);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [3:0] tens, ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {8'h00, tens, ones};
  endfunction

  // Monitor: pairs are checked against the scoreboard at each negedge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid", 32'(bus.valid), 32'((cnt_a != 0) && (cnt_b != 0)));
      if (bus.valid) begin
        if (qa.size() > 0 && qb.size() > 0) begin
          chk("entry_1", 32'(bus.entry_1), 32'(qa[0]));
          chk("entry_2", 32'(bus.entry_2), 32'(qb[0]));
          if (bus.rd) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
          end
        end else begin
          checks++;
          failures++;
          $display("FAIL scoreboard: valid=1 with empty expected queue at %0t", $time);
        end
      end else begin
        chk("entry_1_gated", 32'(bus.entry_1), 32'h0);
        chk("entry_2_gated", 32'(bus.entry_2), 32'h0);
      end
    end
  end

  task automatic clear_model();
    qa.delete();
    qb.delete();
    cnt_a = 0; cnt_b = 0;
    exp_bcd = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_count_a"}, 32'(bus.count_a), 32'h0);
    chk({tag, "_count_b"}, 32'(bus.count_b), 32'h0);
    chk({tag, "_valid"}, 32'(bus.valid), 32'h0);
    chk({tag, "_entry_1"}, 32'(bus.entry_1), 32'h0);
    chk({tag, "_flags"}, 32'({bus.bcd_err, bus.overflow, bus.underflow, bus.full_a}), 32'h0);
  endtask

  // Asserts reset asynchronously, checks the cleared state, then releases.
  task automatic do_reset();
    mon_en  = 1'b0;
    reset_n = 1'b0;
    clear_model();
    #1;
    check_idle("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  // One clock of stimulus; the model advances with what the edge should accept.
  task automatic step(input logic wa, input logic [15:0] da, input logic wb,
                      input logic [15:0] db, input logic r, input logic clr);
    logic acc_a, acc_b, popv, s_bcd, s_ovf, s_unf;
    bus.wr_a = wa; bus.data_a = da;
    bus.wr_b = wb; bus.data_b = db;
    bus.rd = r;    bus.err_clr = clr;
    popv  = r && (cnt_a != 0) && (cnt_b != 0);
    acc_a = wa && model_bcd(da) && (cnt_a < 8);
    acc_b = wb && model_bcd(db) && (cnt_b < 8);
    s_bcd = (wa && !model_bcd(da)) || (wb && !model_bcd(db));
    s_ovf = (wa && cnt_a == 8) || (wb && cnt_b == 8);
    s_unf = r && !popv;
    @(posedge clk);
    #1;
    bus.wr_a = 1'b0; bus.wr_b = 1'b0; bus.rd = 1'b0; bus.err_clr = 1'b0;
    if (acc_a) qa.push_back(da);
    if (acc_b) qb.push_back(db);
    cnt_a = cnt_a + int'(acc_a) - int'(popv);
    cnt_b = cnt_b + int'(acc_b) - int'(popv);
    exp_bcd = s_bcd ? 1'b1 : (clr ? 1'b0 : exp_bcd);
    exp_ovf = s_ovf ? 1'b1 : (clr ? 1'b0 : exp_ovf);
    exp_unf = s_unf ? 1'b1 : (clr ? 1'b0 : exp_unf);
    chk("count_a", 32'(bus.count_a), 32'(cnt_a));
    chk("count_b", 32'(bus.count_b), 32'(cnt_b));
    chk("full_a", 32'(bus.full_a), 32'(cnt_a == 8));
    chk("full_b", 32'(bus.full_b), 32'(cnt_b == 8));
    chk("bcd_err", 32'(bus.bcd_err), 32'(exp_bcd));
    chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
    chk("underflow", 32'(bus.underflow), 32'(exp_unf));
  endtask

  initial begin
    checks = 0; failures = 0;
    mon_en = 1'b0;
    bus.wr_a = 1'b0; bus.data_a = 16'h0; bus.wr_b = 1'b0; bus.data_b = 16'h0;
    bus.rd = 1'b0; bus.err_clr = 1'b0;
    reset_n = 1'b1;
    clear_model();
    do_reset();

    // Simple pair in, pair out.
    step(1'b1, 16'h0012, 1'b1, 16'h0034, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

    // A runs ahead; joining B exposes the oldest A entry.
    do_reset();
    for (int i = 1; i <= 3; i++) step(1'b1, 16'(i * 257), 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 16'h0002, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Fill A, then a write on a full queue races a pop: write is dropped.
    do_reset();
    step(1'b1, 16'h1000, 1'b1, 16'h0042, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0009, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 16'h1008, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h00F0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Malformed BCD is rejected; clear drops the flag.
    do_reset();
    step(1'b1, 16'h00A5, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 16'h9A00, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);

    // Underflow, and set-beats-clear in the same cycle.
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);

    // Streaming at one pair per cycle; pointers wrap several times.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, to_bcd(i), 1'b1, to_bcd(i + 50), i > 0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, to_bcd(i + 20), 1'b1, to_bcd(i + 70), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, to_bcd(i + 30), 1'b1, to_bcd(i + 80), 1'b1, 1'b0);

    // Reset mid-stream empties everything at once.
    do_reset();
    step(1'b1, 16'h0099, 1'b1, 16'h0088, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
